// File: rtl/rf_initiator_if.sv
// rf_initiator_if: command, register-file and response signals of rf_initiator.
interface rf_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rs1;
  logic [4:0]  cmd_rs2;
  logic [4:0]  cmd_rd;
  logic [15:0] cmd_imm;
  logic [2:0]  rf_instr;
  logic [4:0]  rf_read1;
  logic [4:0]  rf_read2;
  logic [4:0]  rf_write;
  logic [15:0] rf_writed;
  logic [15:0] rf_readd1;
  logic [15:0] rf_readd2;
  logic        rf_done;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm, rf_readd1, rf_readd2, rf_done,
    output cmd_ready, rf_instr, rf_read1, rf_read2, rf_write, rf_writed, rsp_valid, rsp_data, rsp_err
  );
  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm, rf_readd1, rf_readd2, rf_done,
    input  cmd_ready, rf_instr, rf_read1, rf_read2, rf_write, rf_writed, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/rf_initiator.sv
// rf_initiator: runs one ALU command as read / execute / write phases against a register file.
module rf_initiator #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  rf_initiator_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, RESP} state_t;
  state_t state, next;
  logic [2:0] op;
  logic [4:0] rs1, rs2, rd;
  logic [15:0] imm, a, b, result, alu, data;
  logic err, phase, timeout;
  logic [CW-1:0] cnt;
  assign phase = state == READ || state == WRITE;
  assign timeout = phase && !bus.rf_done && cnt == CW'(TIMEOUT);
  always_comb begin
    alu = a;
    case (op)
      3'd0: alu = a + b;
      3'd1: alu = a - b;
      3'd2: alu = a & b;
      3'd3: alu = a | b;
      3'd4: alu = a ^ b;
      3'd6: alu = imm;
      default: alu = a;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // rf_done takes priority over a timeout that expires in the same cycle
  always_comb begin
    next = state;
    case (state)
      IDLE: if (bus.cmd_valid) next = bus.cmd_op == 3'd6 ? EXEC : READ;
      READ: next = bus.rf_done ? EXEC : timeout ? RESP : READ;
      EXEC: next = op == 3'd7 ? RESP : WRITE;
      WRITE: next = bus.rf_done || timeout ? RESP : WRITE;
      RESP: next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= '0;
      rs1 <= '0;
      rs2 <= '0;
      rd <= '0;
      imm <= '0;
      a <= '0;
      b <= '0;
      result <= '0;
      data <= '0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      if (state == IDLE && bus.cmd_valid) begin
        op <= bus.cmd_op;
        rs1 <= bus.cmd_rs1;
        rs2 <= bus.cmd_rs2;
        rd <= bus.cmd_rd;
        imm <= bus.cmd_imm;
      end
      if (state == READ && bus.rf_done) begin
        a <= bus.rf_readd1;
        b <= bus.rf_readd2;
      end
      if (state == EXEC) result <= alu;
      if (next == RESP) data <= timeout ? '0 : (state == EXEC ? alu : result);
      err <= timeout;
      cnt <= phase && next == state ? cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    bus.cmd_ready = state == IDLE;
    bus.rf_instr = state == READ ? (op <= 3'd4 ? 3'b110 : 3'b100) : state == WRITE ? 3'b001 : 3'b000;
    bus.rf_read1 = rs1;
    bus.rf_read2 = rs2;
    bus.rf_write = rd;
    bus.rf_writed = result;
    bus.rsp_valid = state == RESP;
    bus.rsp_err = state == RESP && err;
    bus.rsp_data = data;
  end
endmodule
